// File: rtl/pn_port_alloc_ctrl.sv
// Output-port allocator and injection scheduler for the BLESS router. Grants ports in
// age-rank order (productive first, otherwise deflected), one ejection per cycle, and injection into leftovers.
module pn_port_alloc_ctrl #(
    parameter int NUM_OUT      = 4,
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_WIDTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_valid,
    input  logic [1:0] rank0_dir,
    input  logic [1:0] rank1_dir,
    input  logic [1:0] rank2_dir,
    input  logic [1:0] rank3_dir,
    input  logic [3:0] rank0_ppv,
    input  logic [3:0] rank1_ppv,
    input  logic [3:0] rank2_ppv,
    input  logic [3:0] rank3_ppv,
    input  logic [3:0] sorted_eject,
    input  logic [3:0] sorted_mc,
    input  logic       eject_rdy,
    input  logic       inj_req,
    input  logic [3:0] inj_ppv,
    output logic [2:0] xbar_sel0,
    output logic [2:0] xbar_sel1,
    output logic [2:0] xbar_sel2,
    output logic [2:0] xbar_sel3,
    output logic [3:0] out_valid,
    output logic       eject_valid,
    output logic [1:0] eject_sel,
    output logic       inj_grant,
    output logic       starve
);

    localparam logic [CNT_WIDTH-1:0] LIMIT_C = CNT_WIDTH'(STARVE_LIMIT);

    function automatic logic [3:0] pick_cand(input logic [3:0] ppv, input logic [3:0] free);
        return ((ppv & free) != 4'b0000) ? (ppv & free) : free;
    endfunction

    function automatic logic [3:0] lowest_oh(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    logic [1:0]           rank_dir_s [4];
    logic [3:0]           rank_ppv_s [4];
    logic [3:0]           free_s;
    logic [3:0]           grant_oh_s;
    logic                 need_port_s;
    logic [2:0]           sel_s [NUM_OUT];
    logic [3:0]           out_valid_s;
    logic                 eject_valid_s;
    logic [1:0]           eject_sel_s;
    logic                 inj_grant_s;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;

    logic [2:0]           sel_r [NUM_OUT];
    logic [3:0]           out_valid_r;
    logic                 eject_valid_r;
    logic [1:0]           eject_sel_r;
    logic                 inj_grant_r;
    logic                 starve_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    assign rank_dir_s[0] = rank0_dir;
    assign rank_dir_s[1] = rank1_dir;
    assign rank_dir_s[2] = rank2_dir;
    assign rank_dir_s[3] = rank3_dir;
    assign rank_ppv_s[0] = rank0_ppv;
    assign rank_ppv_s[1] = rank1_ppv;
    assign rank_ppv_s[2] = rank2_ppv;
    assign rank_ppv_s[3] = rank3_ppv;

    // Rank-ordered allocation: eject slot, then port grant, then injection into what is left.
    always_comb begin
        free_s        = 4'b1111;
        grant_oh_s    = 4'b0000;
        need_port_s   = 1'b0;
        out_valid_s   = 4'b0000;
        eject_valid_s = 1'b0;
        eject_sel_s   = 2'd0;
        inj_grant_s   = 1'b0;
        for (int p = 0; p < NUM_OUT; p++) begin
            sel_s[p] = 3'd7;
        end
        for (int k = 0; k < 4; k++) begin
            if (!in_valid[rank_dir_s[k]]) begin
                need_port_s = 1'b0;
            end else if (sorted_eject[k] && eject_rdy && !eject_valid_s) begin
                eject_valid_s = 1'b1;
                eject_sel_s   = rank_dir_s[k];
                need_port_s   = sorted_mc[k];
            end else begin
                need_port_s = 1'b1;
            end
            grant_oh_s = (need_port_s && (free_s != 4'b0000))
                       ? lowest_oh(pick_cand(rank_ppv_s[k], free_s)) : 4'b0000;
            for (int p = 0; p < NUM_OUT; p++) begin
                sel_s[p] = grant_oh_s[p] ? {1'b0, rank_dir_s[k]} : sel_s[p];
            end
            out_valid_s = out_valid_s | grant_oh_s;
            free_s      = free_s & ~grant_oh_s;
        end
        inj_grant_s = inj_req && (free_s != 4'b0000);
        grant_oh_s  = inj_grant_s ? lowest_oh(pick_cand(inj_ppv, free_s)) : 4'b0000;
        for (int p = 0; p < NUM_OUT; p++) begin
            sel_s[p] = grant_oh_s[p] ? 3'd4 : sel_s[p];
        end
        out_valid_s = out_valid_s | grant_oh_s;
    end

    // Starvation counter: clears on a grant or an idle request, saturates at the limit.
    always_comb begin
        if (!inj_req || inj_grant_s) begin
            cnt_nxt_s = {CNT_WIDTH{1'b0}};
        end else if (cnt_r != LIMIT_C) begin
            cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Output and counter registers; starve follows the registered counter by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_OUT; p++) begin
                sel_r[p] <= 3'd7;
            end
            out_valid_r   <= 4'b0000;
            eject_valid_r <= 1'b0;
            eject_sel_r   <= 2'd0;
            inj_grant_r   <= 1'b0;
            starve_r      <= 1'b0;
            cnt_r         <= {CNT_WIDTH{1'b0}};
        end else begin
            for (int p = 0; p < NUM_OUT; p++) begin
                sel_r[p] <= sel_s[p];
            end
            out_valid_r   <= out_valid_s;
            eject_valid_r <= eject_valid_s;
            eject_sel_r   <= eject_sel_s;
            inj_grant_r   <= inj_grant_s;
            starve_r      <= (cnt_r == LIMIT_C);
            cnt_r         <= cnt_nxt_s;
        end
    end

    assign xbar_sel0   = sel_r[0];
    assign xbar_sel1   = sel_r[1];
    assign xbar_sel2   = sel_r[2];
    assign xbar_sel3   = sel_r[3];
    assign out_valid   = out_valid_r;
    assign eject_valid = eject_valid_r;
    assign eject_sel   = eject_sel_r;
    assign inj_grant   = inj_grant_r;
    assign starve      = starve_r;

    pn_port_alloc_ctrl_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (rank0_dir),
        .d1    (rank1_dir),
        .d2    (rank2_dir),
        .d3    (rank3_dir)
    );

endmodule

// Input-legality checker: the permutation network must present four distinct rank directions.
module pn_port_alloc_ctrl_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [1:0] d0,
    input logic [1:0] d1,
    input logic [1:0] d2,
    input logic [1:0] d3
);

    a_unique_dirs: assert property (@(posedge clk) disable iff (!rst_n)
        (d0 != d1) && (d0 != d2) && (d0 != d3) && (d1 != d2) && (d1 != d3) && (d2 != d3))
        else $error("duplicate rank direction presented to allocator");

endmodule

// File: tb/tb_pn_port_alloc_ctrl.sv
// Self-checking bench for pn_port_alloc_ctrl: directed test-plan steps plus randomized
// traffic, compared against an ownership-table model of the allocation rules.
module tb_pn_port_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [1:0] dir [4];
    logic [3:0] ppv [4];
    logic [3:0] sorted_eject;
    logic [3:0] sorted_mc;
    logic       eject_rdy;
    logic       inj_req;
    logic [3:0] inj_ppv;
    logic [2:0] xs [4];
    logic [3:0] out_valid;
    logic       eject_valid;
    logic [1:0] eject_sel;
    logic       inj_grant;
    logic       starve;

    int errors = 0;
    int checks = 0;

    int exp_sel [4];
    int exp_ov;
    int exp_ev;
    int exp_es;
    int exp_ig;
    int m_cnt = 0;
    int m_starve = 0;

    always #5 clk = ~clk;

    pn_port_alloc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .rank0_dir    (dir[0]),
        .rank1_dir    (dir[1]),
        .rank2_dir    (dir[2]),
        .rank3_dir    (dir[3]),
        .rank0_ppv    (ppv[0]),
        .rank1_ppv    (ppv[1]),
        .rank2_ppv    (ppv[2]),
        .rank3_ppv    (ppv[3]),
        .sorted_eject (sorted_eject),
        .sorted_mc    (sorted_mc),
        .eject_rdy    (eject_rdy),
        .inj_req      (inj_req),
        .inj_ppv      (inj_ppv),
        .xbar_sel0    (xs[0]),
        .xbar_sel1    (xs[1]),
        .xbar_sel2    (xs[2]),
        .xbar_sel3    (xs[3]),
        .out_valid    (out_valid),
        .eject_valid  (eject_valid),
        .eject_sel    (eject_sel),
        .inj_grant    (inj_grant),
        .starve       (starve)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pick a port from an owner table: productive free port first, else lowest free.
    function automatic int pick_port(input int owner [4], input logic [3:0] want);
        for (int q = 0; q < 4; q++) if (owner[q] < 0 && want[q]) return q;
        for (int q = 0; q < 4; q++) if (owner[q] < 0) return q;
        return -1;
    endfunction

    task automatic model_alloc();
        int owner [4];
        int p;
        for (int q = 0; q < 4; q++) owner[q] = -1;
        exp_ev = 0; exp_es = 0; exp_ig = 0;
        for (int k = 0; k < 4; k++) begin
            if (!in_valid[dir[k]]) continue;
            if (sorted_eject[k] && eject_rdy && exp_ev == 0) begin
                exp_ev = 1;
                exp_es = int'(dir[k]);
                if (!sorted_mc[k]) continue;
            end
            p = pick_port(owner, ppv[k]);
            if (p >= 0) owner[p] = int'(dir[k]);
        end
        if (inj_req) begin
            p = pick_port(owner, inj_ppv);
            if (p >= 0) begin
                owner[p] = 4;
                exp_ig = 1;
            end
        end
        exp_ov = 0;
        for (int q = 0; q < 4; q++) begin
            exp_sel[q] = (owner[q] < 0) ? 7 : owner[q];
            if (owner[q] >= 0) exp_ov += (1 << q);
        end
    endtask

    task automatic compare_all(input string tag);
        for (int q = 0; q < 4; q++) chk($sformatf("%s.sel%0d", tag, q), int'(xs[q]), exp_sel[q]);
        chk({tag, ".out_valid"}, int'(out_valid), exp_ov);
        chk({tag, ".eject_valid"}, int'(eject_valid), exp_ev);
        if (exp_ev == 1) chk({tag, ".eject_sel"}, int'(eject_sel), exp_es);
        chk({tag, ".inj_grant"}, int'(inj_grant), exp_ig);
        chk({tag, ".starve"}, int'(starve), m_starve);
    endtask

    // One clock: predict from current inputs, clock, advance starvation model, compare.
    task automatic cycle(input string tag);
        int req_now;
        model_alloc();
        req_now = int'(inj_req);
        @(posedge clk);
        #1;
        m_starve = (m_cnt >= 15) ? 1 : 0;
        if (req_now == 0 || exp_ig == 1) m_cnt = 0;
        else if (m_cnt < 15) m_cnt = m_cnt + 1;
        compare_all(tag);
    endtask

    task automatic set_ranks(input int d0, input int d1, input int d2, input int d3);
        dir[0] = 2'(d0); dir[1] = 2'(d1); dir[2] = 2'(d2); dir[3] = 2'(d3);
    endtask

    task automatic reset_outputs_chk(input string tag);
        for (int q = 0; q < 4; q++) chk($sformatf("%s.sel%0d", tag, q), int'(xs[q]), 7);
        chk({tag, ".out_valid"}, int'(out_valid), 0);
        chk({tag, ".eject_valid"}, int'(eject_valid), 0);
        chk({tag, ".eject_sel"}, int'(eject_sel), 0);
        chk({tag, ".inj_grant"}, int'(inj_grant), 0);
        chk({tag, ".starve"}, int'(starve), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 4'hF; set_ranks(0, 1, 2, 3);
        for (int k = 0; k < 4; k++) ppv[k] = 4'b0001;
        sorted_eject = 4'b0000; sorted_mc = 4'b0000; eject_rdy = 1'b1;
        inj_req = 1'b0; inj_ppv = 4'b0000;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_outputs_chk("reset");
        m_cnt = 0; m_starve = 0;

        // Release with everything idle.
        in_valid = 4'h0;
        rst_n = 1'b1;
        cycle("idle");
        reset_outputs_chk("idle_rst");

        // No conflict.
        in_valid = 4'hF; set_ranks(2, 0, 3, 1);
        ppv[0] = 4'b0001; ppv[1] = 4'b0010; ppv[2] = 4'b0100; ppv[3] = 4'b1000;
        cycle("noconf");
        chk("noconf.sel0", int'(xs[0]), 2);
        chk("noconf.sel3", int'(xs[3]), 1);

        // Contention: all want port 0.
        set_ranks(0, 1, 2, 3);
        for (int k = 0; k < 4; k++) ppv[k] = 4'b0001;
        cycle("contend");
        chk("contend.sel2", int'(xs[2]), 2);

        // Eject with multicast, slot already taken by rank0.
        in_valid = 4'b1010; set_ranks(1, 3, 0, 2);
        ppv[0] = 4'b0001; ppv[1] = 4'b0100;
        sorted_eject = 4'b0011; sorted_mc = 4'b0010; eject_rdy = 1'b1;
        cycle("eject_mc");
        chk("eject_mc.sel_ch", int'(eject_sel), 1);
        chk("eject_mc.sel2", int'(xs[2]), 3);

        // Eject blocked: flit deflected.
        in_valid = 4'b0001; set_ranks(0, 1, 2, 3);
        ppv[0] = 4'b0000; sorted_eject = 4'b0001; sorted_mc = 4'b0000; eject_rdy = 1'b0;
        cycle("eject_blk");
        chk("eject_blk.sel0", int'(xs[0]), 0);

        // Injection into productive leftover.
        in_valid = 4'b0011; ppv[0] = 4'b0001; ppv[1] = 4'b0010;
        sorted_eject = 4'b0000; eject_rdy = 1'b1;
        inj_req = 1'b1; inj_ppv = 4'b1000;
        cycle("inject");
        chk("inject.sel3", int'(xs[3]), 4);

        // Starvation: every port occupied while injection waits.
        in_valid = 4'hF;
        for (int i = 0; i < 17; i++) cycle($sformatf("starve_%0d", i));
        chk("starve.raised", int'(starve), 1);
        in_valid = 4'b0111;
        cycle("starve_drop");
        chk("starve_drop.grant", int'(inj_grant), 1);
        cycle("starve_clear");
        chk("starve_clear.starve", int'(starve), 0);

        // Randomized traffic with permuted rank directions.
        for (int i = 0; i < 300; i++) begin
            int perm [4];
            int j, t;
            for (int k = 0; k < 4; k++) perm[k] = k;
            for (int k = 3; k > 0; k--) begin
                j = $urandom_range(0, k);
                t = perm[k]; perm[k] = perm[j]; perm[j] = t;
            end
            set_ranks(perm[0], perm[1], perm[2], perm[3]);
            for (int k = 0; k < 4; k++) ppv[k] = 4'($urandom);
            in_valid = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            sorted_eject = 4'($urandom);
            sorted_mc = 4'($urandom);
            eject_rdy = 1'($urandom);
            inj_req = ($urandom_range(0, 4) != 0);
            inj_ppv = 4'($urandom);
            cycle($sformatf("rand_%0d", i));
        end

        // Asynchronous reset in the middle of a cycle.
        in_valid = 4'hF; inj_req = 1'b1;
        cycle("pre_mid_rst");
        #3 rst_n = 1'b0;
        #1;
        reset_outputs_chk("mid_rst");
        m_cnt = 0; m_starve = 0;
        #2 rst_n = 1'b1;
        cycle("post_mid_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
